fifo: RTL and testbench
=======================

Name: fifo

Overview:
- Synchronous first-in-first-out buffer; the queue-ordered counterpart of the team's stack (lifo) block.
- Used wherever a producer and a consumer on the same clock need elastic decoupling with arrival order preserved.
- Valid/ready handshake on both the write side and the read side.
- Read side is first-word-fall-through: head data is presented without a read request.

Parameters:
- WIDTH, 8, data word width in bits (>=1).
- DEPTH, 16, number of entries; must be a power of 2 and >=2.
- AF_THRESH, 14, almost_full asserts when count >= AF_THRESH (1..DEPTH).
- AE_THRESH, 2, almost_empty asserts when count <= AE_THRESH (0..DEPTH-1).

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- flush  in  1  synchronous clear; discards all entries.
- wr_valid  in  1  producer has a word on wr_data.
- wr_ready  out  1  FIFO can accept a word this cycle.
- wr_data  in  WIDTH  write data.
- rd_valid  out  1  head word present on rd_data.
- rd_ready  in  1  consumer takes the head word this cycle.
- rd_data  out  WIDTH  head word; forced to 0 when rd_valid=0.
- count  out  $clog2(DEPTH)+1  current occupancy, 0..DEPTH.
- almost_full  out  1  count >= AF_THRESH.
- almost_empty  out  1  count <= AE_THRESH.

Behaviour:
- Interface: one clock clk; reset rst_n is asynchronous, active-low. Assertion clears state immediately; deassertion is used synchronously.
- Reset values:
  - wr_rd pointers = 0 and count = 0.
  - wr_ready = 1, rd_valid = 0, rd_data = 0.
  - almost_full = 0; almost_empty = 1.
  - Storage array is not reset.
- Pointers: wr_ptr and rd_ptr are $clog2(DEPTH)+1 bits wide; the MSB is the wrap bit.
  - empty when the pointers are equal.
  - full when the low bits are equal and the MSBs differ.
  - Increment wraps naturally at 2*DEPTH.
- Write handshake: push = wr_valid & wr_ready. On push, mem[wr_ptr low bits] <= wr_data and wr_ptr++.
- Read handshake: pop = rd_valid & rd_ready. On pop, rd_ptr++.
- Combinational flags and data:
  - wr_ready = !full.
  - rd_valid = !empty.
  - rd_data = mem[rd_ptr low bits] when rd_valid, else 0.
- Latency:
  - A word pushed in cycle N is visible on rd_data/rd_valid in cycle N+1. There is no same-cycle passthrough when empty.
  - wr_ready rises the cycle after a pop from full. Push while full is never accepted, even if a pop occurs in the same cycle.
- Simultaneous push and pop (not empty, not full): both pointers advance and count is unchanged.
- Pop while empty: no effect, because rd_valid=0 makes the handshake false.
- count: registered. Updates +1 on push only, -1 on pop only, unchanged on both or neither. Never exceeds DEPTH and never underflows.
- almost_full and almost_empty are registered, derived from next-count so they align with count. Both may be asserted together for small DEPTH.
- flush: takes priority over push and pop in the same cycle.
  - Next cycle: pointers = 0, count = 0, rd_valid = 0, wr_ready = 1.
  - Any push in the flush cycle is discarded.
- Reset mid-operation: all contents are lost; outputs return to reset values asynchronously.
- No overflow or underflow is possible through the handshake; no error flags exist.

Decomposition:
- No shared package needed. Derived widths are localparams:
  - AW = $clog2(DEPTH).
  - CW = AW+1.
- One natural sub-module: fifo_mem, a parameterised WIDTH x DEPTH storage array.
  - One synchronous write port and one asynchronous read port.
  - No reset.
  - Reusable by the lifo block.
- Elaboration-time checks: DEPTH is a power of 2; the thresholds are in range.

Test Plan:
- Reset then idle (DEPTH=16) -> wr_ready=1, rd_valid=0, rd_data=0, count=0, almost_empty=1, almost_full=0.
- Push 16 words 0x00..0x0F with rd_ready=0, then drain with rd_ready=1:
  - count reaches 16, wr_ready=0, almost_full=1 from count=14.
  - Reads return 0x00..0x0F in order.
  - rd_valid drops after the 16th pop.
- While full, hold wr_valid=1 with data 0xAA and pop one word:
  - 0xAA is not accepted in the pop cycle.
  - It is accepted the next cycle; count goes 16 -> 15 -> 16.
- At count=5, drive continuous simultaneous push/pop for 40 cycles:
  - count stays 5 and the pointers wrap at least twice.
  - Output order matches a scoreboard model.
- Push 0x55 into the empty FIFO -> rd_valid=1 and rd_data=0x55 exactly one cycle later; rd_data is 0 before that.
- flush asserted at count=9 together with wr_valid=1 -> next cycle count=0 and rd_valid=0; the flushed-cycle word is never read.
- Assert rst_n=0 asynchronously mid-burst at count=7 -> outputs return to reset values immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/fifo_mem.sv
// fifo_mem: WIDTH x DEPTH storage array with one synchronous write port
// and one asynchronous (combinational) read port. Not reset.
module fifo_mem #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     wr_en,
  input  logic [$clog2(DEPTH)-1:0] wr_addr,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic [$clog2(DEPTH)-1:0] rd_addr,
  output logic [WIDTH-1:0]         rd_data
);

  logic [WIDTH-1:0] mem [DEPTH];

  // Write the addressed word on the rising edge when enabled
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  // Present the addressed word combinationally
  always_comb begin
    rd_data = mem[rd_addr];
  end

endmodule

// File: rtl/fifo.sv
// fifo: synchronous first-word-fall-through FIFO with valid/ready
// handshakes on both sides, registered occupancy count and
// registered almost_full / almost_empty flags.
module fifo #(
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned DEPTH     = 16,
  parameter int unsigned AF_THRESH = 14,
  parameter int unsigned AE_THRESH = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     flush,
  input  logic                     wr_valid,
  output logic                     wr_ready,
  input  logic [WIDTH-1:0]         wr_data,
  output logic                     rd_valid,
  input  logic                     rd_ready,
  output logic [WIDTH-1:0]         rd_data,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     almost_full,
  output logic                     almost_empty
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  localparam logic [CW-1:0] AF_T = CW'(AF_THRESH);
  localparam logic [CW-1:0] AE_T = CW'(AE_THRESH);

  if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
    $error("fifo: DEPTH must be a power of 2 and >= 2");
  end
  if ((AF_THRESH < 1) || (AF_THRESH > DEPTH)) begin : g_bad_af
    $error("fifo: AF_THRESH must be in 1..DEPTH");
  end
  if (AE_THRESH > (DEPTH - 1)) begin : g_bad_ae
    $error("fifo: AE_THRESH must be in 0..DEPTH-1");
  end

  logic [CW-1:0]    wr_ptr;
  logic [CW-1:0]    rd_ptr;
  logic [CW-1:0]    count_next;
  logic             full;
  logic             empty;
  logic             push;
  logic             pop;
  logic [WIDTH-1:0] head;

  // Pointer-derived status and handshakes; MSB of each pointer is the wrap bit
  always_comb begin
    empty    = (wr_ptr == rd_ptr);
    full     = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);
    wr_ready = !full;
    rd_valid = !empty;
    push     = wr_valid && wr_ready;
    pop      = rd_valid && rd_ready;
  end

  // Words written in a flush cycle are discarded, so the array write is gated too
  fifo_mem #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_mem (
    .clk     (clk),
    .wr_en   (push && !flush),
    .wr_addr (wr_ptr[AW-1:0]),
    .wr_data (wr_data),
    .rd_addr (rd_ptr[AW-1:0]),
    .rd_data (head)
  );

  // Head word is forced to zero whenever nothing is valid
  always_comb begin
    rd_data = rd_valid ? head : '0;
  end

  // Advance pointers on handshakes; flush overrides both
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + CW'(1);
      if (pop)  rd_ptr <= rd_ptr + CW'(1);
    end
  end

  // Next occupancy: +1 push only, -1 pop only, else unchanged
  always_comb begin
    count_next = count;
    if (flush) begin
      count_next = '0;
    end else begin
      unique case ({push, pop})
        2'b10:   count_next = count + CW'(1);
        2'b01:   count_next = count - CW'(1);
        default: count_next = count;
      endcase
    end
  end

  // Register count and flags together so the flags align with count
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count        <= '0;
      almost_full  <= 1'b0;
      almost_empty <= 1'b1;
    end else begin
      count        <= count_next;
      almost_full  <= (count_next >= AF_T);
      almost_empty <= (count_next <= AE_T);
    end
  end

endmodule

// File: tb/tb_fifo.sv
// tb_fifo: directed bench for fifo (DEPTH=16) with a queue scoreboard
// and a behavioural occupancy model.
module tb_fifo;

  logic       clk;
  logic       rst_n;
  logic       flush;
  logic       wr_valid;
  logic       wr_ready;
  logic [7:0] wr_data;
  logic       rd_valid;
  logic       rd_ready;
  logic [7:0] rd_data;
  logic [4:0] count;
  logic       almost_full;
  logic       almost_empty;

  int unsigned n_assert;
  int unsigned n_fail;
  logic [7:0]  sb [$];

  fifo #(
    .WIDTH     (8),
    .DEPTH     (16),
    .AF_THRESH (14),
    .AE_THRESH (2)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .flush        (flush),
    .wr_valid     (wr_valid),
    .wr_ready     (wr_ready),
    .wr_data      (wr_data),
    .rd_valid     (rd_valid),
    .rd_ready     (rd_ready),
    .rd_data      (rd_data),
    .count        (count),
    .almost_full  (almost_full),
    .almost_empty (almost_empty)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Compare all outputs against the model, then drive one clock cycle
  task automatic cycle(input logic wv, input logic [7:0] wd, input logic rr, input logic fl);
    int unsigned cnt;
    logic        full_m;
    logic        empty_m;
    logic        do_push;
    logic        do_pop;
    cnt     = sb.size();
    full_m  = (cnt == 16);
    empty_m = (cnt == 0);
    wr_valid = wv;
    wr_data  = wd;
    rd_ready = rr;
    flush    = fl;
    check("wr_ready", 32'(wr_ready), 32'(!full_m));
    check("rd_valid", 32'(rd_valid), 32'(!empty_m));
    check("count", 32'(count), cnt);
    check("almost_full", 32'(almost_full), 32'(cnt >= 14));
    check("almost_empty", 32'(almost_empty), 32'(cnt <= 2));
    check("rd_data", 32'(rd_data), empty_m ? 32'h0 : 32'(sb[0]));
    do_push = wv && !full_m;
    do_pop  = rr && !empty_m;
    @(posedge clk);
    #1;
    if (fl) begin
      sb.delete();
    end else begin
      if (do_pop)  void'(sb.pop_front());
      if (do_push) sb.push_back(wd);
    end
  endtask

  initial begin
    n_assert = 0;
    n_fail   = 0;
    rst_n    = 1'b0;
    flush    = 1'b0;
    wr_valid = 1'b0;
    wr_data  = '0;
    rd_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Reset then idle
    check("reset_count", 32'(count), 32'd0);
    check("reset_ae", 32'(almost_empty), 32'd1);
    repeat (2) cycle(1'b0, 8'h00, 1'b0, 1'b0);

    // Fill with 0x00..0x0F, confirm full, then drain in order
    for (int i = 0; i < 16; i++) cycle(1'b1, 8'(i), 1'b0, 1'b0);
    check("full_count", 32'(count), 32'd16);
    check("full_wr_ready", 32'(wr_ready), 32'd0);
    for (int i = 0; i < 16; i++) begin
      check("drain_order", 32'(rd_data), 32'(i));
      cycle(1'b0, 8'h00, 1'b1, 1'b0);
    end
    check("drained_rd_valid", 32'(rd_valid), 32'd0);

    // Refill; push while full is refused in the pop cycle, accepted next cycle
    for (int i = 0; i < 16; i++) cycle(1'b1, 8'(8'h20 + i), 1'b0, 1'b0);
    cycle(1'b1, 8'hAA, 1'b1, 1'b0);
    check("aa_refused_count", 32'(count), 32'd15);
    cycle(1'b1, 8'hAA, 1'b0, 1'b0);
    check("aa_accepted_count", 32'(count), 32'd16);
    check("aa_tail", 32'(sb[15]), 32'hAA);

    // Drain down to 5, then 40 cycles of simultaneous push/pop
    for (int i = 0; i < 11; i++) cycle(1'b0, 8'h00, 1'b1, 1'b0);
    check("at_five", 32'(count), 32'd5);
    for (int i = 0; i < 40; i++) begin
      cycle(1'b1, 8'($urandom_range(0, 255)), 1'b1, 1'b0);
      check("steady_count", 32'(count), 32'd5);
    end
    for (int i = 0; i < 5; i++) cycle(1'b0, 8'h00, 1'b1, 1'b0);

    // First-word-fall-through latency from empty
    check("pre55_rd_data", 32'(rd_data), 32'd0);
    cycle(1'b1, 8'h55, 1'b0, 1'b0);
    check("post55_rd_valid", 32'(rd_valid), 32'd1);
    check("post55_rd_data", 32'(rd_data), 32'h55);
    cycle(1'b0, 8'h00, 1'b1, 1'b0);

    // Flush at count 9 together with a write
    for (int i = 0; i < 9; i++) cycle(1'b1, 8'(8'h40 + i), 1'b0, 1'b0);
    check("preflush_count", 32'(count), 32'd9);
    cycle(1'b1, 8'hEE, 1'b0, 1'b1);
    check("flush_count", 32'(count), 32'd0);
    check("flush_rd_valid", 32'(rd_valid), 32'd0);
    check("flush_wr_ready", 32'(wr_ready), 32'd1);
    repeat (2) cycle(1'b0, 8'h00, 1'b1, 1'b0);

    // Asynchronous reset mid-burst at count 7
    for (int i = 0; i < 7; i++) cycle(1'b1, 8'(8'h60 + i), 1'b0, 1'b0);
    check("prereset_count", 32'(count), 32'd7);
    wr_valid = 1'b1;
    wr_data  = 8'h77;
    #2;
    rst_n = 1'b0;
    #1;
    check("async_count", 32'(count), 32'd0);
    check("async_rd_valid", 32'(rd_valid), 32'd0);
    check("async_rd_data", 32'(rd_data), 32'd0);
    check("async_wr_ready", 32'(wr_ready), 32'd1);
    check("async_af", 32'(almost_full), 32'd0);
    check("async_ae", 32'(almost_empty), 32'd1);
    sb.delete();
    wr_valid = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (2) cycle(1'b0, 8'h00, 1'b0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
